// File: rtl/linear_layer_seq.sv
// Time-multiplexed fixed-point linear layer with valid/ready handshakes on both sides.
// LANES shared MAC units walk the NOUT neurons group by group; results are rescaled and saturated.
module linear_layer_seq #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int NIN   = 4,
    parameter int NOUT  = 4,
    parameter int LANES = 2,
    parameter logic [WIDTH*NIN*NOUT-1:0] WEIGHTS_MATRIX_FLAT = '0,
    parameter logic [WIDTH*NOUT-1:0]     BIAS_FLAT           = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in [NIN],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out [NOUT],
    output logic                    sat
);

    localparam int G     = NOUT / LANES;
    localparam int ACC_W = 2*WIDTH + $clog2(NIN) + 1;
    localparam int SUM_W = ACC_W + 1;
    localparam int K_W   = (NIN > 1) ? $clog2(NIN) : 1;
    localparam int G_W   = (G > 1) ? $clog2(G) : 1;
    localparam int N_W   = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam logic signed [SUM_W-1:0] MAX_V = {{(SUM_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIN_V = {{(SUM_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t r_state, w_nextState;

    logic signed [WIDTH-1:0] r_inReg [NIN];
    logic signed [WIDTH-1:0] r_out   [NOUT];
    logic signed [ACC_W-1:0] r_acc   [LANES];
    logic [K_W-1:0]          r_k;
    logic [G_W-1:0]          r_g;
    logic                    r_sat;

    logic signed [WIDTH-1:0]   w_weight    [NOUT][NIN];
    logic signed [WIDTH-1:0]   w_bias      [NOUT];
    logic [N_W-1:0]            w_nIdx      [LANES];
    logic signed [2*WIDTH-1:0] w_prod      [LANES];
    logic signed [ACC_W-1:0]   w_accNext   [LANES];
    logic signed [SUM_W-1:0]   w_biasExt   [LANES];
    logic signed [SUM_W-1:0]   w_sum       [LANES];
    logic signed [SUM_W-1:0]   w_shift     [LANES];
    logic signed [WIDTH-1:0]   w_clipped   [LANES];
    logic [LANES-1:0]          w_clip;
    logic                      w_lastK;
    logic                      w_lastG;

    // Neuron 0 row sits at the MSB end of the flat weight vector, input 0 at each row's MSB end.
    for (genvar n = 0; n < NOUT; n++) begin : g_unpack
        assign w_bias[n] = BIAS_FLAT[WIDTH*NOUT-1-n*WIDTH -: WIDTH];
        for (genvar k = 0; k < NIN; k++) begin : g_row
            assign w_weight[n][k] = WEIGHTS_MATRIX_FLAT[WIDTH*NIN*NOUT-1-(n*NIN+k)*WIDTH -: WIDTH];
        end
    end

    assign w_lastK = (r_k == K_W'(NIN-1));
    assign w_lastG = (r_g == G_W'(G-1));

    always_comb begin
        w_clip = '0;
        for (int l = 0; l < LANES; l++) begin
            w_nIdx[l]    = N_W'(int'(r_g)*LANES + l);
            w_prod[l]    = r_inReg[r_k] * w_weight[w_nIdx[l]][r_k];
            w_accNext[l] = r_acc[l] + {{(ACC_W-2*WIDTH){w_prod[l][2*WIDTH-1]}}, w_prod[l]};
            w_biasExt[l] = {{(SUM_W-WIDTH){w_bias[w_nIdx[l]][WIDTH-1]}}, w_bias[w_nIdx[l]]};
            w_sum[l]     = {w_accNext[l][ACC_W-1], w_accNext[l]} + (w_biasExt[l] <<< FRAC);
            w_shift[l]   = w_sum[l] >>> FRAC;
            if (w_shift[l] > MAX_V) begin
                w_clipped[l] = {1'b0, {(WIDTH-1){1'b1}}};
                w_clip[l]    = 1'b1;
            end else if (w_shift[l] < MIN_V) begin
                w_clipped[l] = {1'b1, {(WIDTH-1){1'b0}}};
                w_clip[l]    = 1'b1;
            end else begin
                w_clipped[l] = w_shift[l][WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_nextState = MAC;
            end
            MAC: begin
                if (w_lastK && w_lastG) w_nextState = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // The input bus is only sampled on accept; the MAC pass reads the latched copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NIN; i++)   r_inReg[i] <= '0;
            for (int i = 0; i < NOUT; i++)  r_out[i]   <= '0;
            for (int l = 0; l < LANES; l++) r_acc[l]   <= '0;
            r_k   <= '0;
            r_g   <= '0;
            r_sat <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_inReg <= in;
                        for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
                        r_k   <= '0;
                        r_g   <= '0;
                        r_sat <= 1'b0;
                    end
                end
                MAC: begin
                    if (w_lastK) begin
                        for (int l = 0; l < LANES; l++) begin
                            r_out[w_nIdx[l]] <= w_clipped[l];
                            r_acc[l]         <= '0;
                        end
                        r_sat <= r_sat | (|w_clip);
                        r_k   <= '0;
                        r_g   <= w_lastG ? '0 : r_g + 1'b1;
                    end else begin
                        for (int l = 0; l < LANES; l++) r_acc[l] <= w_accNext[l];
                        r_k <= r_k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out = r_out;
    assign sat = r_sat;

endmodule

// File: tb/tb_linear_layer_seq.sv
// Bench for linear_layer_seq: four instances with different weight/bias sets run in lockstep,
// a scoreboard queue holds expected results and a negedge monitor compares on each handshake.
module tb_linear_layer_seq;

    localparam int FRAC = 8;

    typedef logic [3:0][15:0] vec_t;
    typedef struct packed {
        logic [3:0]     s;
        vec_t [3:0]     o;
    } exp_t;

    localparam logic [255:0] W0 = {16'h0100, 16'h0000, 16'h0000, 16'h0000,
                                   16'h0000, 16'h0100, 16'h0000, 16'h0000,
                                   16'h0000, 16'h0000, 16'h0100, 16'h0000,
                                   16'h0000, 16'h0000, 16'h0000, 16'h0100};
    localparam logic [255:0] W2 = {16{16'h7FFF}};
    localparam logic [255:0] W3 = {16'h0080, 16'hFF00, 16'h0040, 16'h0120,
                                   16'hFFC0, 16'h0200, 16'hFE80, 16'h0010,
                                   16'h0100, 16'h0100, 16'hFF80, 16'h0033,
                                   16'h7000, 16'h8800, 16'h0001, 16'hFFFF};
    localparam logic [63:0]  B0 = 64'h0;
    localparam logic [63:0]  B1 = {16'h0001, 16'hFFFF, 16'h0000, 16'h7FFF};
    localparam logic [63:0]  B3 = {16'h0005, 16'hFFF0, 16'h1234, 16'h8001};

    logic clk = 1'b0;
    logic rst_n;
    logic inValid;
    logic outReadyFixed;
    logic randReady;
    logic rndReady;
    logic outReady;
    logic signed [15:0] inVec [4];
    logic [3:0] inRdy, outVld, satV;
    logic signed [15:0] out0 [4];
    logic signed [15:0] out1 [4];
    logic signed [15:0] out2 [4];
    logic signed [15:0] out3 [4];
    vec_t gotPk [4];

    exp_t sbQ [$];
    int   checks = 0;
    int   errors = 0;
    int   edgeCnt = 0;
    int   acceptEdge = 0;
    logic prevValid = 1'b0;

    always #5 clk = ~clk;

    assign outReady = randReady ? rndReady : outReadyFixed;
    assign gotPk[0] = {out0[3], out0[2], out0[1], out0[0]};
    assign gotPk[1] = {out1[3], out1[2], out1[1], out1[0]};
    assign gotPk[2] = {out2[3], out2[2], out2[1], out2[0]};
    assign gotPk[3] = {out3[3], out3[2], out3[1], out3[0]};

    linear_layer_seq #(.WEIGHTS_MATRIX_FLAT(W0), .BIAS_FLAT(B0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inRdy[0]), .in(inVec),
        .out_valid(outVld[0]), .out_ready(outReady), .out(out0), .sat(satV[0]));
    linear_layer_seq #(.WEIGHTS_MATRIX_FLAT(W0), .BIAS_FLAT(B1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inRdy[1]), .in(inVec),
        .out_valid(outVld[1]), .out_ready(outReady), .out(out1), .sat(satV[1]));
    linear_layer_seq #(.WEIGHTS_MATRIX_FLAT(W2), .BIAS_FLAT(B0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inRdy[2]), .in(inVec),
        .out_valid(outVld[2]), .out_ready(outReady), .out(out2), .sat(satV[2]));
    linear_layer_seq #(.WEIGHTS_MATRIX_FLAT(W3), .BIAS_FLAT(B3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inRdy[3]), .in(inVec),
        .out_valid(outVld[3]), .out_ready(outReady), .out(out3), .sat(satV[3]));

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    initial begin
        rndReady = 1'b0;
        forever begin
            @(posedge clk);
            #1 rndReady = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic signed [15:0] wAt(input int d, input int n, input int k);
        logic [255:0] m;
        case (d)
            0, 1:    m = W0;
            2:       m = W2;
            default: m = W3;
        endcase
        return m[255-(n*4+k)*16 -: 16];
    endfunction

    function automatic logic signed [15:0] bAt(input int d, input int n);
        logic [63:0] m;
        case (d)
            1:       m = B1;
            3:       m = B3;
            default: m = B0;
        endcase
        return m[63-n*16 -: 16];
    endfunction

    function automatic exp_t modelAll(input vec_t v);
        exp_t   e;
        longint acc;
        e = '0;
        for (int d = 0; d < 4; d++) begin
            for (int n = 0; n < 4; n++) begin
                acc = 0;
                for (int k = 0; k < 4; k++)
                    acc += longint'($signed(v[k])) * longint'(wAt(d, n, k));
                acc = (acc + (longint'(bAt(d, n)) <<< FRAC)) >>> FRAC;
                if (acc > 32767) begin
                    acc = 32767;
                    e.s[d] = 1'b1;
                end else if (acc < -32768) begin
                    acc = -32768;
                    e.s[d] = 1'b1;
                end
                e.o[d][n] = acc[15:0];
            end
        end
        return e;
    endfunction

    function automatic vec_t mkVec(input int a0, input int a1, input int a2, input int a3);
        vec_t v;
        v[0] = a0[15:0];
        v[1] = a1[15:0];
        v[2] = a2[15:0];
        v[3] = a3[15:0];
        return v;
    endfunction

    // Instances 0..2 take hand-computed results; instance 3 uses the reference model.
    function automatic exp_t mkExp(input vec_t v, input vec_t e0, input vec_t e1, input vec_t e2,
                                   input logic [2:0] s);
        exp_t e;
        e = modelAll(v);
        e.o[0] = e0;
        e.o[1] = e1;
        e.o[2] = e2;
        e.s[2:0] = s;
        return e;
    endfunction

    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_result got out=%h with empty scoreboard, required none", gotPk[0]);
        end else begin
            e = sbQ.pop_front();
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (gotPk[d] !== e.o[d] || satV[d] !== e.s[d]) begin
                    errors++;
                    $display("[TB] FAIL result_dut%0d got out=%h sat=%b, required out=%h sat=%b",
                             d, gotPk[d], satV[d], e.o[d], e.s[d]);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prevValid = 1'b0;
        end else begin
            if (outVld[0] && !prevValid) begin
                checks++;
                if (edgeCnt - acceptEdge != 8) begin
                    errors++;
                    $display("[TB] FAIL latency got %0d edges, required 8", edgeCnt - acceptEdge);
                end
            end
            if (inValid && inRdy[0]) acceptEdge = edgeCnt + 1;
            if (outVld[0] && outReady) checkOutput();
            prevValid = outVld[0];
        end
    end

    task automatic applyStimulus(input vec_t v, input exp_t e);
        int waited;
        sbQ.push_back(e);
        for (int i = 0; i < 4; i++) inVec[i] = v[i];
        inValid = 1'b1;
        waited  = 0;
        @(negedge clk);
        while (!inRdy[0] && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!inRdy[0]) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout got in_ready=%b after %0d cycles, required 1", inRdy[0], waited);
        end
        @(posedge clk);
        #1 inValid = 1'b0;
    endtask

    task automatic waitDrain(input int limit);
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d pending results, required 0", sbQ.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (gotPk[d] !== '0 || outVld[d] !== 1'b0 || satV[d] !== 1'b0 || inRdy[d] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s_dut%0d got out=%h valid=%b sat=%b in_ready=%b, required 0/0/0/1",
                         tag, d, gotPk[d], outVld[d], satV[d], inRdy[d]);
            end
        end
    endtask

    initial begin
        #1000000;
        errors++;
        $display("[TB] FAIL watchdog got no completion, required finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        vec_t snapOut;
        logic snapSat;
        vec_t v;
        int   n;
        rst_n         = 1'b1;
        inValid       = 1'b0;
        outReadyFixed = 1'b1;
        randReady     = 1'b0;
        for (int i = 0; i < 4; i++) inVec[i] = '0;
        #1 rst_n = 1'b0;
        #2 checkResetState("reset");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        v = mkVec(256, -512, 768, 1024);
        applyStimulus(v, mkExp(v, v, mkVec(257, -513, 768, 32767),
                               mkVec(32767, 32767, 32767, 32767), 3'b110));
        v = mkVec(0, 0, 0, 0);
        applyStimulus(v, mkExp(v, v, mkVec(1, -1, 0, 32767), v, 3'b000));
        v = mkVec(32767, 32767, 32767, 32767);
        applyStimulus(v, mkExp(v, v, mkVec(32767, 32766, 32767, 32767), v, 3'b110));
        v = mkVec(-32768, -32768, -32768, -32768);
        applyStimulus(v, mkExp(v, v, mkVec(-32767, -32768, -32768, -1), v, 3'b110));
        waitDrain(100);

        // Stall in DONE with a new vector already offered.
        outReadyFixed = 1'b0;
        v = mkVec(100, -3, 0, 7);
        applyStimulus(v, mkExp(v, v, mkVec(101, -4, 0, 32767),
                               mkVec(13311, 13311, 13311, 13311), 3'b010));
        n = 0;
        while (!outVld[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        snapOut = gotPk[0];
        snapSat = satV[0];
        @(posedge clk);
        #1;
        v = mkVec(-1, 0, 0, 0);
        sbQ.push_back(mkExp(v, v, mkVec(0, -1, 0, 32767), mkVec(-128, -128, -128, -128), 3'b000));
        for (int i = 0; i < 4; i++) inVec[i] = v[i];
        inValid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (outVld[0] !== 1'b1 || inRdy[0] !== 1'b0 || gotPk[0] !== snapOut || satV[0] !== snapSat) begin
                errors++;
                $display("[TB] FAIL stall_hold got valid=%b in_ready=%b out=%h sat=%b, required 1/0/%h/%b",
                         outVld[0], inRdy[0], gotPk[0], satV[0], snapOut, snapSat);
            end
        end
        @(posedge clk);
        #1 outReadyFixed = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (inRdy[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reaccept got in_ready=%b, required 1", inRdy[0]);
        end
        @(posedge clk);
        #1 inValid = 1'b0;
        waitDrain(100);

        // Abort mid-MAC with an asynchronous reset pulse.
        v = mkVec(1, 2, 3, 4);
        applyStimulus(v, modelAll(v));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetState("abort");
        sbQ.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        v = mkVec(-256, 512, -1, 3);
        applyStimulus(v, mkExp(v, v, mkVec(-255, 511, -1, 32767),
                               mkVec(32767, 32767, 32767, 32767), 3'b110));
        waitDrain(100);

        randReady = 1'b1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            v = mkVec(int'($urandom()), int'($urandom()), int'($urandom()), int'($urandom()));
            applyStimulus(v, modelAll(v));
        end
        waitDrain(500);
        randReady = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
